// File: rtl/ras_predecode.sv
// ras_predecode: call/return predecoder feeding the return address stack.
// Classifies JAL/JALR/branches using the x1/x5 link-register rules and issues
// exactly one set of RAS push/pop/checkpoint controls per instruction.
// A pop-then-push (coroutine) JALR is split over two cycles by a small FSM.
// Optional feature macro: RAS_PREDECODE_RVC_EN enables compressed (RVC) decode.
module ras_predecode #(
    parameter int PC_BITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               must_flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_BITS-1:0] in_pc,
    input  logic [31:0]        in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_BITS-1:0] out_pc,
    output logic [31:0]        out_instr,
    output logic               out_pred_valid,
    output logic [PC_BITS-1:0] out_pred_target,
    input  logic [PC_BITS-1:0] ras_top,
    input  logic               ras_empty,
    output logic               ras_push,
    output logic               ras_pop,
    output logic [PC_BITS-1:0] ras_new_entry,
    output logic               ras_is_branch
);

    typedef enum logic [1:0] {ST_EMPTY, ST_HOLD, ST_SWAP} state_t;
    typedef enum logic [2:0] {CL_NONE, CL_PUSH, CL_POP, CL_SWAP, CL_CKPT} cls_t;

    state_t             state;
    cls_t               cls_in;
    cls_t               cls_p1;
    logic               is_c_in;
    logic               is_c_p1;
    logic [PC_BITS-1:0] pc_p1;
    logic [31:0]        instr_p1;
    logic [PC_BITS-1:0] tgt_p1;
    logic               pvld_p1;
    logic               vld_p1;
    logic               kill;
    logic               fire;
    logic               accept;
    logic [6:0]         opcode;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [PC_BITS-1:0] link_step_p1;

    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign rs1    = in_instr[19:15];

    // Classify the incoming word so the class is stored alongside it at accept.
    always_comb begin
        cls_in  = CL_NONE;
        is_c_in = 1'b0;
        case (opcode)
            7'b1101111: if (is_link(rd)) cls_in = CL_PUSH;
            7'b1100111: begin
                if (is_link(rd) && is_link(rs1) && (rd != rs1)) cls_in = CL_SWAP;
                else if (is_link(rd))                         cls_in = CL_PUSH;
                else if (is_link(rs1))                        cls_in = CL_POP;
            end
            7'b1100011: cls_in = CL_CKPT;
            default: ;
        endcase
`ifdef RAS_PREDECODE_RVC_EN
        if (in_instr[1:0] != 2'b11) begin
            is_c_in = 1'b1;
            cls_in  = CL_NONE;
            if (in_instr[1:0] == 2'b01 && in_instr[15:13] == 3'b001) begin
                cls_in = CL_PUSH;
            end else if (in_instr[1:0] == 2'b01 && in_instr[15:14] == 2'b11) begin
                cls_in = CL_CKPT;
            end else if (in_instr[1:0] == 2'b10 && in_instr[6:2] == 5'd0 && rd != 5'd0) begin
                // rd field holds rs1 in CR-format jumps
                if (in_instr[15:12] == 4'b1000) begin
                    cls_in = is_link(rd) ? CL_POP : CL_NONE;
                end else if (in_instr[15:12] == 4'b1001) begin
                    cls_in = (rd == 5'd5) ? CL_SWAP : CL_PUSH;
                end
            end
        end
`endif
    end

    // Handshake and RAS command generation; rst/flush suppress everything.
    assign kill   = rst | must_flush;
    assign vld_p1 = (state == ST_HOLD);
    assign fire   = vld_p1 & out_ready;

    // Input readiness follows the FSM state, forced low in a reset/flush cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!kill) begin
            case (state)
                ST_EMPTY: in_ready = 1'b1;
                ST_HOLD:  in_ready = out_ready;
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign accept        = in_valid & in_ready;
    assign out_valid     = vld_p1;
    assign ras_push      = fire & ~kill & ((cls_p1 == CL_PUSH) | (cls_p1 == CL_SWAP));
    assign ras_pop       = ~kill & ((state == ST_SWAP) | (fire & (cls_p1 == CL_POP)));
    assign ras_is_branch = fire & ~kill & (cls_p1 == CL_CKPT);

    assign out_pc        = vld_p1 ? pc_p1 : '0;
    assign out_instr     = vld_p1 ? instr_p1 : '0;
    assign link_step_p1  = is_c_p1 ? PC_BITS'(2) : PC_BITS'(4);
    assign ras_new_entry = vld_p1 ? (pc_p1 + link_step_p1) : '0;

    // Return prediction: live TOS for plain returns, captured TOS for swaps.
    always_comb begin
        out_pred_valid  = 1'b0;
        out_pred_target = '0;
        if (vld_p1) begin
            if (cls_p1 == CL_POP) begin
                out_pred_valid  = ~ras_empty;
                out_pred_target = ras_top;
            end else if (cls_p1 == CL_SWAP) begin
                out_pred_valid  = pvld_p1;
                out_pred_target = tgt_p1;
            end
        end
    end

    // FSM: EMPTY -> HOLD, or EMPTY -> SWAP -> HOLD for coroutine swaps.
    always_ff @(posedge clk) begin
        if (kill) begin
            state <= ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= (cls_in == CL_SWAP) ? ST_SWAP : ST_HOLD;
                ST_SWAP:  state <= ST_HOLD;
                ST_HOLD: begin
                    if (fire) begin
                        if (accept) state <= (cls_in == CL_SWAP) ? ST_SWAP : ST_HOLD;
                        else        state <= ST_EMPTY;
                    end
                end
                default:  state <= ST_EMPTY;
            endcase
        end
    end

    // Output register stage p1: word, class and swap-captured prediction.
    always_ff @(posedge clk) begin
        if (accept) begin
            pc_p1    <= in_pc;
            instr_p1 <= in_instr;
            cls_p1   <= cls_in;
            is_c_p1  <= is_c_in;
        end
        if (state == ST_SWAP) begin
            tgt_p1  <= ras_top;
            pvld_p1 <= ~ras_empty;
        end
    end

endmodule

// File: tb/tb_ras_predecode.sv
// tb_ras_predecode: directed scenarios followed by a random stream, checked
// against a transaction-level model (one in-flight slot plus a RAS stack).
module tb_ras_predecode;

    localparam int PC_BITS = 32;
    localparam int K_NONE = 0, K_PUSH = 1, K_POP = 2, K_SWAP = 3, K_CKPT = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               must_flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [PC_BITS-1:0] in_pc = '0;
    logic [31:0]        in_instr = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_BITS-1:0] out_pc;
    logic [31:0]        out_instr;
    logic               out_pred_valid;
    logic [PC_BITS-1:0] out_pred_target;
    logic [PC_BITS-1:0] ras_top = '0;
    logic               ras_empty = 1'b1;
    logic               ras_push;
    logic               ras_pop;
    logic [PC_BITS-1:0] ras_new_entry;
    logic               ras_is_branch;

    ras_predecode #(.PC_BITS(PC_BITS)) dut (
        .clk(clk), .rst(rst), .must_flush(must_flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_pred_valid(out_pred_valid), .out_pred_target(out_pred_target),
        .ras_top(ras_top), .ras_empty(ras_empty), .ras_push(ras_push), .ras_pop(ras_pop),
        .ras_new_entry(ras_new_entry), .ras_is_branch(ras_is_branch)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // model: the single instruction held by the block, and the RAS contents
    bit          have = 0;
    logic [31:0] m_pc, m_ins, m_tgt;
    int          m_cls;
    bit          m_c, m_swapped, m_pv;
    logic [31:0] stk[$];

    // observed values of the last step, for directed spot checks
    logic        s_ov, s_ir, s_push, s_pop, s_br, s_pv;
    logic [31:0] s_new, s_tgt;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic bit lnk(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

    function automatic bit is_comp(input logic [31:0] w);
`ifdef RAS_PREDECODE_RVC_EN
        return w[1:0] != 2'b11;
`else
        return (w[0] & 1'b0) != 1'b0;
`endif
    endfunction

    // Reference classification, straight from the link-register rule table.
    function automatic int ref_class(input logic [31:0] w);
        logic [4:0] rd, rs1;
        rd  = w[11:7];
        rs1 = w[19:15];
        if (w[1:0] != 2'b11) begin
`ifdef RAS_PREDECODE_RVC_EN
            if (w[1:0] == 2'b01 && w[15:13] == 3'b001) return K_PUSH;
            if (w[1:0] == 2'b01 && (w[15:13] == 3'b110 || w[15:13] == 3'b111)) return K_CKPT;
            if (w[1:0] == 2'b10 && w[6:2] == 5'd0 && rd != 5'd0 && w[15:12] == 4'b1000)
                return lnk(rd) ? K_POP : K_NONE;
            if (w[1:0] == 2'b10 && w[6:2] == 5'd0 && rd != 5'd0 && w[15:12] == 4'b1001)
                return (rd == 5'd5) ? K_SWAP : K_PUSH;
`endif
            return K_NONE;
        end
        if (w[6:0] == 7'b1101111) return lnk(rd) ? K_PUSH : K_NONE;
        if (w[6:0] == 7'b1100111) begin
            if (!lnk(rd) && !lnk(rs1)) return K_NONE;
            if (!lnk(rd)) return K_POP;
            if (!lnk(rs1)) return K_PUSH;
            return (rd == rs1) ? K_PUSH : K_SWAP;
        end
        if (w[6:0] == 7'b1100011) return K_CKPT;
        return K_NONE;
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'd3;
        endcase
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 10))
            0:       return {r[31:12], pick_reg(), 7'h6F};
            1, 2:    return {r[31:20], pick_reg(), 3'b000, pick_reg(), 7'h67};
            3:       return {r[31:7], 7'h63};
            4:       return {r[31:7], 7'h13};
            5:       return {r[31:16], 3'b001, r[12:2], 2'b01};
            6:       return {r[31:16], 4'b1000, pick_reg(), 5'd0, 2'b10};
            7:       return {r[31:16], 4'b1001, pick_reg(), 5'd0, 2'b10};
            8:       return {r[31:16], 2'b11, r[13:2], 2'b01};
            9:       return {r[31:16], r[15:2], 2'b00};
            default: return r;
        endcase
    endfunction

    // One clock cycle: drive, check every output against the model, advance the model.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic rs);
        bit kill, bubble, e_ov, e_ir, e_fire, e_push, e_pop, e_br, emp;
        logic [31:0] top, e_new;
        @(negedge clk);
        in_valid   = iv;
        in_pc      = pc;
        in_instr   = ins;
        out_ready  = ordy;
        must_flush = fl;
        rst        = rs;
        emp        = (stk.size() == 0);
        top        = emp ? 32'h0 : stk[stk.size()-1];
        ras_empty  = emp;
        ras_top    = top;
        #1;
        kill   = fl || rs;
        bubble = have && m_cls == K_SWAP && !m_swapped;
        e_ov   = have && !bubble;
        e_ir   = kill ? 1'b0 : (!have ? 1'b1 : (bubble ? 1'b0 : ordy));
        e_fire = e_ov && ordy;
        e_push = !kill && e_fire && (m_cls == K_PUSH || m_cls == K_SWAP);
        e_pop  = !kill && (bubble || (e_fire && m_cls == K_POP));
        e_br   = !kill && e_fire && m_cls == K_CKPT;
        e_new  = m_pc + (m_c ? 32'd2 : 32'd4);

        chk1("out_valid", out_valid, e_ov);
        chk1("in_ready", in_ready, e_ir);
        chk1("ras_push", ras_push, e_push);
        chk1("ras_pop", ras_pop, e_pop);
        chk1("ras_is_branch", ras_is_branch, e_br);
        chk1("push_pop_excl", ras_push & ras_pop, 1'b0);
        if (e_ov) begin
            chkw("out_pc", out_pc, m_pc);
            chkw("out_instr", out_instr, m_ins);
            chkw("ras_new_entry", ras_new_entry, e_new);
            if (m_cls == K_POP) begin
                chk1("pred_valid_pop", out_pred_valid, !emp);
                chkw("pred_target_pop", out_pred_target, top);
            end else if (m_cls == K_SWAP) begin
                chk1("pred_valid_swap", out_pred_valid, m_pv);
                chkw("pred_target_swap", out_pred_target, m_tgt);
            end else begin
                chk1("pred_valid_none", out_pred_valid, 1'b0);
                chkw("pred_target_none", out_pred_target, 32'h0);
            end
        end
        s_ov = out_valid; s_ir = in_ready; s_push = ras_push; s_pop = ras_pop;
        s_br = ras_is_branch; s_pv = out_pred_valid; s_new = ras_new_entry; s_tgt = out_pred_target;

        if (kill) begin
            have = 0;
        end else begin
            if (bubble) begin
                m_tgt = top;
                m_pv = !emp;
                m_swapped = 1;
                if (!emp) void'(stk.pop_back());
            end
            if (e_pop && !bubble && !emp) void'(stk.pop_back());
            if (e_push) begin
                stk.push_back(e_new);
                if (stk.size() > 16) void'(stk.pop_front());
            end
            if (e_fire) have = 0;
            if (iv && e_ir) begin
                have = 1; m_pc = pc; m_ins = ins; m_cls = ref_class(ins);
                m_c = is_comp(ins); m_swapped = 0; m_pv = 0; m_tgt = 32'h0;
            end
        end
        @(posedge clk);
    endtask

    initial begin
        // reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_push", ras_push, 1'b0);
        chk1("rst_pop", ras_pop, 1'b0);
        chk1("rst_branch", ras_is_branch, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
        chk1("post_rst_out_valid", out_valid, 1'b0);
        chkw("post_rst_out_pc", out_pc, 32'h0);
        chkw("post_rst_out_instr", out_instr, 32'h0);
        chkw("post_rst_new_entry", ras_new_entry, 32'h0);
        chk1("post_rst_pred_valid", out_pred_valid, 1'b0);
        chkw("post_rst_pred_target", out_pred_target, 32'h0);
        @(posedge clk);

        // JAL x1 -> push of pc+4
        step(1, 32'h1000, 32'h000000EF, 1, 0, 0);
        chk1("jal_accept_ready", s_ir, 1'b1);
        step(0, 0, 0, 1, 0, 0);
        chk1("jal_out_valid", s_ov, 1'b1);
        chk1("jal_push", s_push, 1'b1);
        chkw("jal_new_entry", s_new, 32'h1004);

        // JALR x0,0(x1) -> return predicted from TOS, pop on fire
        step(1, 32'h2000, 32'h00008067, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk1("ret_pred_valid", s_pv, 1'b1);
        chkw("ret_pred_target", s_tgt, 32'h1004);
        chk1("ret_pop", s_pop, 1'b1);

        // JALR x1,0(x5) -> pop bubble then push
        stk.push_back(32'h4444);
        step(1, 32'h3000, 32'h000280E7, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        chk1("swap_c1_pop", s_pop, 1'b1);
        chk1("swap_c1_out_valid", s_ov, 1'b0);
        chk1("swap_c1_push", s_push, 1'b0);
        step(0, 0, 0, 1, 0, 0);
        chk1("swap_c2_out_valid", s_ov, 1'b1);
        chkw("swap_c2_target", s_tgt, 32'h4444);
        chk1("swap_c2_push", s_push, 1'b1);
        chk1("swap_c2_pop", s_pop, 1'b0);
        chkw("swap_c2_new_entry", s_new, 32'h3004);

        // BEQ then ADDI with a 3-cycle downstream stall
        step(1, 32'h5000, 32'h00000063, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h5004, 32'h00000013, 0, 0, 0);
            chk1("stall_in_ready", s_ir, 1'b0);
            chk1("stall_branch", s_br, 1'b0);
        end
        step(1, 32'h5004, 32'h00000013, 1, 0, 0);
        chk1("beq_fire_branch", s_br, 1'b1);
        step(0, 0, 0, 1, 0, 0);
        chk1("addi_no_branch", s_br, 1'b0);
        chk1("addi_out_valid", s_ov, 1'b1);

        // flush during the swap bubble cancels pop and pending push
        stk.push_back(32'h7777);
        step(1, 32'h6000, 32'h000280E7, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk1("flush_swap_pop", s_pop, 1'b0);
        chk1("flush_swap_in_ready", s_ir, 1'b0);
        step(0, 0, 0, 1, 0, 0);
        chk1("after_flush_out_valid", s_ov, 1'b0);
        chk1("after_flush_in_ready", s_ir, 1'b1);
        chk1("after_flush_push", s_push, 1'b0);

        // C.JAL at the top of the address space
        step(1, 32'hFFFF_FFFE, 32'h0000_2001, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);
`ifdef RAS_PREDECODE_RVC_EN
        chk1("cjal_push", s_push, 1'b1);
        chkw("cjal_new_entry_wrap", s_new, 32'h0000_0000);
`else
        chk1("cjal_no_push", s_push, 1'b0);
        chkw("cjal_new_entry_32b", s_new, 32'h0000_0002);
`endif

        // random stream with stalls, flushes and occasional resets
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) < 70, $urandom() & 32'hFFFF_FFFE, gen_instr(),
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 199) == 0);
        end
        step(0, 0, 0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
